// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with error-tagged first-word-fall-through read FIFO
// Optional break detection (adds break_det) is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_fifo #(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         BAUD_RATE    = 115200,
    parameter int         OVERSAMPLING = 16,
    parameter int         DATA_BITS    = 8,
    parameter int         PARITY_MODE  = 0,
    parameter int         STOP_BITS    = 1,
    parameter int         FIFO_DEPTH   = 32,
    parameter logic [7:0] EOS_CHAR     = 8'h0A
) (
    input  logic                        clk_50mhz,
    input  logic                        rst_n,
    input  logic                        rx_in,
    input  logic                        flush,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic                        rd_frame_err,
    output logic                        rd_parity_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_full,
    output logic                        overflow,
    output logic                        eos_pulse
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                        break_det
`endif
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLING);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = $clog2(DIV + 1);
    localparam int SAMP_W  = $clog2(OVERSAMPLING);
    localparam int MID     = OVERSAMPLING / 2;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_BITS + 2;
    localparam logic [DATA_BITS-1:0] EOS_MASK = DATA_BITS'(9'h0FF);
    localparam bit   EOS_FITS = (DATA_BITS >= 8) || ((EOS_CHAR >> DATA_BITS) == 8'h00);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t state_q, state_d;

    logic rx_meta, rx_sync, rx_prev;
    logic fall;

    logic [DIV_W-1:0]     tick_cnt;
    logic [SAMP_W-1:0]    sample_cnt;
    logic [1:0]           samp_hist;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 frame_err_r;
    logic                 parity_err_r;

    logic tick, mid_tick, bit_end, maj, parity_exp, last_stop, stop_mid;
    logic wr_strobe;
    logic [ENTRY_W-1:0] wr_entry;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall       = rx_prev & ~rx_sync;
    assign tick       = (tick_cnt == DIV_W'(DIV - 1));
    assign mid_tick   = tick && (sample_cnt == SAMP_W'(MID));
    assign bit_end    = tick && (sample_cnt == SAMP_W'(OVERSAMPLING - 1));
    // Vote over the samples at ticks MID-2, MID-1 and the one arriving now at MID.
    assign maj        = (samp_hist[1] & samp_hist[0]) | (samp_hist[1] & rx_sync) | (samp_hist[0] & rx_sync);
    assign parity_exp = (PARITY_MODE == 1) ? ~(^shift_reg) : ^shift_reg;
    assign last_stop  = (stop_idx == 1'(STOP_BITS - 1));
    assign stop_mid   = (state_q == ST_STOP) && mid_tick && last_stop;
    assign wr_entry   = {shift_reg, frame_err_r | ~maj, parity_err_r};

`ifdef UART_RX_BREAK_DETECT_EN
    logic              all_zero_r;
    logic [SAMP_W-1:0] high_cnt;
    logic              is_break, high_done;

    assign is_break  = all_zero_r && !maj;
    assign high_done = tick && rx_sync && (high_cnt == SAMP_W'(OVERSAMPLING - 1));
    assign wr_strobe = stop_mid && !is_break;
    assign break_det = (state_q == ST_BREAK);
`else
    assign wr_strobe = stop_mid;
`endif

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                if (mid_tick && maj) state_d = ST_IDLE;
                else if (bit_end)    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == 4'(DATA_BITS - 1)))
                    state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
`ifdef UART_RX_BREAK_DETECT_EN
                if (stop_mid) state_d = is_break ? ST_BREAK : ST_IDLE;
`else
                if (stop_mid) state_d = ST_IDLE;
`endif
            end
`ifdef UART_RX_BREAK_DETECT_EN
            ST_BREAK: begin
                if (high_done) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt     <= '0;
            sample_cnt   <= '0;
            samp_hist    <= 2'b11;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shift_reg    <= '0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero_r   <= 1'b1;
            high_cnt     <= '0;
`endif
        end else if (state_q == ST_IDLE) begin
            // Free-running divider; realigned to the start edge so sampling is centred on the bit.
            tick_cnt     <= (fall || tick) ? '0 : tick_cnt + 1'b1;
            sample_cnt   <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero_r   <= 1'b1;
            high_cnt     <= '0;
`endif
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                sample_cnt <= bit_end ? '0 : sample_cnt + 1'b1;
                samp_hist  <= {samp_hist[0], rx_sync};
            end
            case (state_q)
                ST_DATA: begin
                    if (mid_tick) shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                    if (bit_end)  bit_idx   <= bit_idx + 4'd1;
                end
                ST_PARITY: begin
                    if (mid_tick && (maj != parity_exp)) parity_err_r <= 1'b1;
                end
                ST_STOP: begin
                    if (mid_tick && !maj) frame_err_r <= 1'b1;
                    if (bit_end)          stop_idx    <= stop_idx + 1'b1;
                end
`ifdef UART_RX_BREAK_DETECT_EN
                ST_BREAK: begin
                    if (tick) high_cnt <= rx_sync ? high_cnt + 1'b1 : '0;
                end
`endif
                default: ;
            endcase
`ifdef UART_RX_BREAK_DETECT_EN
            if (mid_tick && maj && (state_q != ST_BREAK)) all_zero_r <= 1'b0;
`endif
        end
    end

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               push, pop, dropped, eos_match;

    assign rd_valid  = (fifo_count != '0);
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop       = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign push      = wr_strobe && (!fifo_full || pop) && !flush;
    assign dropped   = wr_strobe && fifo_full && !pop && !flush;
    assign eos_match = EOS_FITS && ((shift_reg & EOS_MASK) == DATA_BITS'(EOS_CHAR));

    always_ff @(posedge clk_50mhz) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            eos_pulse  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            eos_pulse  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (dropped) overflow <= 1'b1;
            eos_pulse <= push && eos_match;
        end
    end

    assign head          = mem[rd_ptr];
    assign rd_data       = rd_valid ? head[ENTRY_W-1:2] : '0;
    assign rd_frame_err  = rd_valid & head[1];
    assign rd_parity_err = rd_valid & head[0];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo over three parameterisations
module tb_uart_rx_fifo;

    logic clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    logic       rst_n;
    logic [2:0] rx, flush, rd_ready;
    logic [2:0] rd_valid, rd_fe, rd_pe, full, ovf, eos;
    logic [7:0] rd_data [3];
    logic [5:0] cnt [3];
`ifdef UART_RX_BREAK_DETECT_EN
    logic [2:0] brk;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int eos_cnt = 0;
    logic [5:0] eos_at_count = '0;
    logic [9:0] q0[$], q1[$], q2[$];
    logic [9:0] mon_got, mon_want;
    bit         mon_have;

    uart_rx_fifo dut (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n), .rx_in(rx[0]), .flush(flush[0]), .rd_ready(rd_ready[0]),
        .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_frame_err(rd_fe[0]), .rd_parity_err(rd_pe[0]),
        .fifo_count(cnt[0]), .fifo_full(full[0]), .overflow(ovf[0]), .eos_pulse(eos[0])
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk[0])
`endif
    );

    uart_rx_fifo #(.BAUD_RATE(781250)) dut_fast (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n), .rx_in(rx[1]), .flush(flush[1]), .rd_ready(rd_ready[1]),
        .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_frame_err(rd_fe[1]), .rd_parity_err(rd_pe[1]),
        .fifo_count(cnt[1]), .fifo_full(full[1]), .overflow(ovf[1]), .eos_pulse(eos[1])
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk[1])
`endif
    );

    uart_rx_fifo #(.BAUD_RATE(781250), .PARITY_MODE(2)) dut_par (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n), .rx_in(rx[2]), .flush(flush[2]), .rd_ready(rd_ready[2]),
        .rd_valid(rd_valid[2]), .rd_data(rd_data[2]), .rd_frame_err(rd_fe[2]), .rd_parity_err(rd_pe[2]),
        .fifo_count(cnt[2]), .fifo_full(full[2]), .overflow(ovf[2]), .eos_pulse(eos[2])
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic at_pos();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic drive(input int i, input bit v, input int n);
        rx[i] = v;
        repeat (n) @(negedge clk_50mhz);
    endtask

    // Start, 8 data LSB first, optional parity, one stop bit, then one idle bit.
    task automatic send_frame(input int i, input logic [7:0] d, input bit par_en, input bit par, input bit stop);
        int cpb = (i == 0) ? 432 : 64;
        drive(i, 1'b0, cpb);
        for (int b = 0; b < 8; b++) drive(i, d[b], cpb);
        if (par_en) drive(i, par, cpb);
        drive(i, stop, cpb);
        drive(i, 1'b1, cpb);
    endtask

    task automatic wait_drain(input int i);
        int left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_50mhz);
            left = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
            if (left == 0) break;
        end
        check($sformatf("drain%0d_remaining", i), 32'(left), 32'd0);
        repeat (3) @(negedge clk_50mhz);
    endtask

    always @(negedge clk_50mhz) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (rd_valid[i] && rd_ready[i]) begin
                    mon_got  = {rd_data[i], rd_fe[i], rd_pe[i]};
                    mon_have = 1'b0;
                    mon_want = '0;
                    case (i)
                        0: if (q0.size() > 0) begin mon_want = q0.pop_front(); mon_have = 1'b1; end
                        1: if (q1.size() > 0) begin mon_want = q1.pop_front(); mon_have = 1'b1; end
                        default: if (q2.size() > 0) begin mon_want = q2.pop_front(); mon_have = 1'b1; end
                    endcase
                    if (mon_have) begin
                        check($sformatf("pop%0d_entry", i), 32'(mon_got), 32'(mon_want));
                    end else begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pop%0d_unexpected: got entry %0h, expected none", i, mon_got);
                    end
                end
            end
            if (eos[0]) begin
                eos_cnt++;
                eos_at_count = cnt[0];
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rx       = 3'b111;
        flush    = 3'b000;
        rd_ready = 3'b100;
        repeat (4) @(negedge clk_50mhz);
        check("rst_valid", 32'(rd_valid[0]), 32'd0);
        check("rst_count", 32'(cnt[0]), 32'd0);
        check("rst_full", 32'(full[0]), 32'd0);
        check("rst_overflow", 32'(ovf[0]), 32'd0);
        check("rst_eos", 32'(eos[0]), 32'd0);
        check("rst_data", 32'(rd_data[0]), 32'd0);
        at_pos();
        rst_n = 1'b1;
        repeat (4) @(negedge clk_50mhz);

        fork
            begin
                q0.push_back({8'h55, 1'b0, 1'b0});
                send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
                check("b55_valid", 32'(rd_valid[0]), 32'd1);
                check("b55_data", 32'(rd_data[0]), 32'h55);
                check("b55_tags", 32'({rd_fe[0], rd_pe[0]}), 32'd0);
                check("b55_count", 32'(cnt[0]), 32'd1);
                at_pos();
                rd_ready[0] = 1'b1;
                wait_drain(0);
                check("b55_count_after", 32'(cnt[0]), 32'd0);

                q0.push_back({8'h3C, 1'b1, 1'b0});
                send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
                q0.push_back({8'h41, 1'b0, 1'b0});
                send_frame(0, 8'h41, 1'b0, 1'b0, 1'b1);
                wait_drain(0);
                check("eos_none_yet", 32'(eos_cnt), 32'd0);

                drive(0, 1'b0, 108);
                drive(0, 1'b1, 3 * 432);
                check("glitch_count", 32'(cnt[0]), 32'd0);
                check("glitch_valid", 32'(rd_valid[0]), 32'd0);

                at_pos();
                rd_ready[0] = 1'b0;
                q0.push_back({8'h4F, 1'b0, 1'b0});
                q0.push_back({8'h4B, 1'b0, 1'b0});
                q0.push_back({8'h0A, 1'b0, 1'b0});
                send_frame(0, 8'h4F, 1'b0, 1'b0, 1'b1);
                send_frame(0, 8'h4B, 1'b0, 1'b0, 1'b1);
                check("ok_eos_before_lf", 32'(eos_cnt), 32'd0);
                send_frame(0, 8'h0A, 1'b0, 1'b0, 1'b1);
                check("ok_count", 32'(cnt[0]), 32'd3);
                check("ok_eos_cycles", 32'(eos_cnt), 32'd1);
                check("ok_eos_after_write", 32'(eos_at_count), 32'd3);
                at_pos();
                rd_ready[0] = 1'b1;
                wait_drain(0);
                check("ok_eos_total", 32'(eos_cnt), 32'd1);
`ifdef UART_RX_BREAK_DETECT_EN
                drive(0, 1'b0, 12 * 432);
                check("break_set", 32'(brk[0]), 32'd1);
                check("break_count", 32'(cnt[0]), 32'd0);
                drive(0, 1'b1, 2 * 432);
                check("break_clear", 32'(brk[0]), 32'd0);
`endif
            end
            begin
                for (int i = 0; i < 33; i++) begin
                    if (i < 32) q1.push_back({8'(i * 7 + 3), 1'b0, 1'b0});
                    send_frame(1, 8'(i * 7 + 3), 1'b0, 1'b0, 1'b1);
                end
                check("ovf_full", 32'(full[1]), 32'd1);
                check("ovf_sticky", 32'(ovf[1]), 32'd1);
                check("ovf_count", 32'(cnt[1]), 32'd32);
                at_pos();
                rd_ready[1] = 1'b1;
                wait_drain(1);
                check("ovf_drained_count", 32'(cnt[1]), 32'd0);
                check("ovf_held", 32'(ovf[1]), 32'd1);
                at_pos();
                rd_ready[1] = 1'b0;
                send_frame(1, 8'h99, 1'b0, 1'b0, 1'b1);
                check("flush_pre_count", 32'(cnt[1]), 32'd1);
                at_pos();
                flush[1] = 1'b1;
                at_pos();
                flush[1] = 1'b0;
                @(negedge clk_50mhz);
                check("flush_count", 32'(cnt[1]), 32'd0);
                check("flush_overflow", 32'(ovf[1]), 32'd0);
                check("flush_valid", 32'(rd_valid[1]), 32'd0);
            end
            begin
                q2.push_back({8'hA5, 1'b0, 1'b1});
                send_frame(2, 8'hA5, 1'b1, 1'b1, 1'b1);
                q2.push_back({8'hA5, 1'b0, 1'b0});
                send_frame(2, 8'hA5, 1'b1, 1'b0, 1'b1);
                q2.push_back({8'h07, 1'b0, 1'b0});
                send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
                wait_drain(2);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
